seq_detector_prog: RTL and testbench

Run-time programmable serial pattern detector for the bit-stream monitoring path. It replaces the fixed-pattern detectors (00100 and similar) with one block. The pattern, its length and overlap mode are loaded through a config port. The block qualifies input bits with a valid strobe, flags each match with a registered pulse, and keeps a saturating match counter for status readout.

---
 rtl/seq_detector_prog.sv | 106 ++++++++++
 tb/tb_seq_detector_prog.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector: qualified bit stream in,
// registered match pulse and saturating match counter out.
module seq_detector_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               detected_q, detected_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;

  // Only the low len_q bits of history and pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
  end

  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc   = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    match      = in_valid && !cfg_load && !err_q && (fill_inc >= len_q) &&
                 (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    err_d      = err_q;
    detected_d = match;
    count_d    = count_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      err_d  = (cfg_len < LEN_W'(2)) || (cfg_len > LEN_W'(MAX_LEN));
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end

    if (clr_count) begin
      count_d = '0;
    end else if (match && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q      <= '0;
      len_q      <= LEN_W'(MAX_LEN);
      ovl_q      <= 1'b1;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      detected_q <= detected_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign detected    = detected_q;
  assign match_count = count_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: a bit-queue reference model pushes
// expected outputs to a scoreboard, popped and compared after each clock edge.
module tb_seq_detector_prog;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .detected(detected), .match_count(match_count), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             det;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: bits received since the last restart, newest at the back.
  bit               mq[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               m_err;
  int               m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = '0;
    m_len = MAX_LEN;
    m_ovl = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
    mq.delete();
    sb.delete();
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr, input bit load);
    exp_t e;
    bit   m;
    m = 1'b0;
    if (v && !load) begin
      mq.push_back(b);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      if (!m_err && mq.size() >= m_len) begin
        m = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (mq[mq.size()-1-k] != m_pat[k]) m = 1'b0;
      end
      if (m && !m_ovl) mq.delete();
    end
    if (clr) m_cnt = 0;
    else if (m && m_cnt < CNT_MAX) m_cnt++;
    e.det = m;
    e.cnt = m_cnt[CNT_W-1:0];
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      tests--;
      e = sb.pop_front();
      check({tag, "_det"}, 32'(detected), 32'(e.det));
      check({tag, "_cnt"}, 32'(match_count), 32'(e.cnt));
      check({tag, "_err"}, 32'(cfg_err), 32'(e.err));
    end
  endtask

  task automatic step(input bit v, input bit b, input bit clr);
    in_valid  = v;
    in_bit    = b;
    clr_count = clr;
    cfg_load  = 1'b0;
    model_step(v, b, clr, 1'b0);
    pop_check("step");
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl,
                      input bit v, input bit b);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    in_valid    = v;
    in_bit      = b;
    clr_count   = 1'b0;
    m_pat = pat;
    m_len = len;
    m_ovl = ovl;
    m_err = (len < 2) || (len > MAX_LEN);
    mq.delete();
    model_step(v, b, 1'b0, 1'b1);
    pop_check("load");
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  // Sends n bits of 'bits', most significant (first received) first.
  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_det", 32'(detected), 32'd0);
    check("rst_cnt", 32'(match_count), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_det", 32'(detected), 32'd0);
    check("rst_hold_cnt", 32'(match_count), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Reset defaults: pattern 0, length MAX_LEN, overlap on
    stream(32'h0, 8);
    check("default_cnt", 32'(match_count), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("clr_cnt", 32'(match_count), 32'd0);

    // Legacy 00100 with overlap
    load(8'b00100, 5, 1'b1, 1'b0, 1'b0);
    stream(32'b00100100, 8);
    check("legacy_cnt", 32'(match_count), 32'd2);
    step(1'b0, 1'b0, 1'b1);

    // 0101 non-overlap then overlap
    load(8'b0101, 4, 1'b0, 1'b0, 1'b0);
    stream(32'b01010101, 8);
    check("novl_cnt", 32'(match_count), 32'd2);
    step(1'b0, 1'b0, 1'b1);
    load(8'b0101, 4, 1'b1, 1'b0, 1'b0);
    stream(32'b01010101, 8);
    check("ovl_cnt", 32'(match_count), 32'd3);
    step(1'b0, 1'b0, 1'b1);

    // Pattern 11 with invalid gaps between the two ones
    load(8'b11, 2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("gap_det", 32'(detected), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // cfg_load together with a valid bit: that bit is dropped
    load(8'b11, 2, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("simul_nodet", 32'(detected), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("simul_cnt", 32'(match_count), 32'd1);

    // Illegal lengths freeze matching; clr still works
    load(8'h00, 0, 1'b1, 1'b0, 1'b0);
    check("err_len0", 32'(cfg_err), 32'd1);
    stream(32'hFF, 8);
    check("err_frozen_cnt", 32'(match_count), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("err_clr_cnt", 32'(match_count), 32'd0);
    load(8'hFF, 9, 1'b1, 1'b0, 1'b0);
    check("err_len9", 32'(cfg_err), 32'd1);
    load(8'hFF, 1, 1'b1, 1'b0, 1'b0);
    check("err_len1", 32'(cfg_err), 32'd1);
    stream(32'hF, 4);
    load(8'b111, 3, 1'b1, 1'b0, 1'b0);
    check("err_cleared", 32'(cfg_err), 32'd0);
    stream(32'b111, 3);
    check("len3_cnt", 32'(match_count), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // Saturation at 15, then clr concurrent with a match
    load(8'b11, 2, 1'b1, 1'b0, 1'b0);
    stream(32'hFFFFF, 20);
    check("sat_cnt", 32'(match_count), 32'd15);
    step(1'b1, 1'b1, 1'b1);
    check("clr_match_det", 32'(detected), 32'd1);
    check("clr_match_cnt", 32'(match_count), 32'd0);

    // Reset in the middle of 00100
    load(8'b00100, 5, 1'b1, 1'b0, 1'b0);
    stream(32'b0010, 4);
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_nodet", 32'(detected), 32'd0);
    load(8'b00100, 5, 1'b1, 1'b0, 1'b0);
    stream(32'b00100, 5);
    check("post_rst_cnt", 32'(match_count), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("pulse_drop", 32'(detected), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
